// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default parameters for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

    localparam int REG_W_DEF        = 5;
    localparam int PC_W_DEF         = 12;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int STALL_CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the instruction in ID reads a register that the load in EX
// has not yet produced.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             lu
);

    logic load_writes;
    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign load_writes = ex_valid & ex_is_load & (ex_rd != '0);
    assign rs1_match   = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_match   = id_use_rs2 & (id_rs2 == ex_rd);
    assign lu          = load_writes & (rs1_match | rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage hold/flush decode, mispredict redirect, memory-busy
// freeze and halt drain, plus a saturating stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int PC_W         = PC_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic [REG_W-1:0]       id_rs1,
    input  logic [REG_W-1:0]       id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   id_halt,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   ex_mispredict,
    input  logic [PC_W-1:0]        ex_target,
    input  logic                   dmem_busy,
    output logic                   pc_latchn,
    output logic                   ifid_latchn,
    output logic                   idex_latchn,
    output logic                   exmem_latchn,
    output logic                   memwb_latchn,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   redirect,
    output logic [PC_W-1:0]        redirect_pc,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       drain_q, drain_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   halted_q, halted_d;
    logic                   stall_inc;
    logic                   lu;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .lu         (lu)
    );

    assign redirect_pc = ex_target;
    assign halted      = halted_q;
    assign stall_cnt   = stall_q;

    always_comb begin
        pc_latchn    = 1'b0;
        ifid_latchn  = 1'b0;
        idex_latchn  = 1'b0;
        exmem_latchn = 1'b0;
        memwb_latchn = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        redirect     = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;
        stall_inc    = 1'b0;

        if (!RSTn) begin
            // Hold every register and present bubbles while reset is applied.
            {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_busy) begin
                        {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn} = 5'b11111;
                        stall_inc = 1'b1;
                    end else if (ex_mispredict) begin
                        redirect   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        pc_latchn   = 1'b1;
                        ifid_latchn = 1'b1;
                        idex_flush  = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (id_halt) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_busy) begin
                        {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn} = 5'b11111;
                        stall_inc = 1'b1;
                    end else begin
                        // Front end frozen; bubbles follow the halt down the pipe.
                        pc_latchn   = 1'b1;
                        ifid_latchn = 1'b1;
                        idex_flush  = 1'b1;
                        if (drain_q == '0) begin
                            state_d = ST_HALT;
                        end else begin
                            drain_d = drain_q - 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn} = 5'b11111;
                end
                default: begin
                    {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn} = 5'b11111;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_d  = (stall_inc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
        halted_d = (state_q == ST_HALT);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            stall_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a RUN-state vector table plus drain, busy-drain
// and reset-in-halt sequences.
module tb_pipeline_ctrl;

    logic        CLK;
    logic        RSTn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, id_halt;
    logic        ex_valid, ex_is_load, ex_mispredict, dmem_busy;
    logic [11:0] ex_target;
    logic        pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn;
    logic        ifid_flush, idex_flush, redirect, halted;
    logic [11:0] redirect_pc;
    logic [15:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_stall = 0;

    pipeline_ctrl dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_halt      (id_halt),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_mispredict(ex_mispredict),
        .ex_target    (ex_target),
        .dmem_busy    (dmem_busy),
        .pc_latchn    (pc_latchn),
        .ifid_latchn  (ifid_latchn),
        .idex_latchn  (idex_latchn),
        .exmem_latchn (exmem_latchn),
        .memwb_latchn (memwb_latchn),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [4:0]  rs1, rs2;
        logic        use1, use2, halt, exv, exld;
        logic [4:0]  exrd;
        logic        misp;
        logic [11:0] tgt;
        logic        busy;
        logic [4:0]  e_latch;
        logic        e_ifl, e_idl, e_redir;
        int          e_sinc;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [4:0] latches();
        return {pc_latchn, ifid_latchn, idex_latchn, exmem_latchn, memwb_latchn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_halt = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_mispredict = 0;
        ex_target = 0; dmem_busy = 0;
    endtask

    task automatic chk_outs(input string name, input logic [4:0] l, input logic ifl,
                            input logic idl, input logic rd);
        chk({name, ".latchn"}, 32'(latches()), 32'(l));
        chk({name, ".ifid_flush"}, 32'(ifid_flush), 32'(ifl));
        chk({name, ".idex_flush"}, 32'(idex_flush), 32'(idl));
        chk({name, ".redirect"}, 32'(redirect), 32'(rd));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        chk_outs("reset", 5'b11111, 1'b1, 1'b1, 1'b0);
        chk("reset.halted", 32'(halted), 32'd0);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        exp_stall = 0;
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        //            name        rs1 rs2 u1 u2 h  v  ld rd mp tgt     bz  latch     ifl idl rd  sinc
        vecs[0]  = '{"normal",     1,  2, 1, 1, 0, 1, 0, 3, 0, 12'h000, 0, 5'b00000, 0, 0, 0, 0};
        vecs[1]  = '{"lu_rs1",     5,  2, 1, 0, 0, 1, 1, 5, 0, 12'h010, 0, 5'b11000, 0, 1, 0, 1};
        vecs[2]  = '{"rd_zero",    0,  0, 1, 1, 0, 1, 1, 0, 0, 12'h020, 0, 5'b00000, 0, 0, 0, 0};
        vecs[3]  = '{"no_use",     5,  7, 0, 1, 0, 1, 1, 5, 0, 12'h030, 0, 5'b00000, 0, 0, 0, 0};
        vecs[4]  = '{"lu_rs2",     3,  9, 0, 1, 0, 1, 1, 9, 0, 12'h044, 0, 5'b11000, 0, 1, 0, 1};
        vecs[5]  = '{"not_load",   9,  9, 1, 1, 0, 1, 0, 9, 0, 12'h055, 0, 5'b00000, 0, 0, 0, 0};
        vecs[6]  = '{"ex_bubble",  9,  9, 1, 1, 0, 0, 1, 9, 0, 12'h066, 0, 5'b00000, 0, 0, 0, 0};
        vecs[7]  = '{"misp_lu",    5,  0, 1, 0, 0, 1, 1, 5, 1, 12'h040, 0, 5'b00000, 1, 1, 1, 0};
        vecs[8]  = '{"busy_lu",    5,  0, 1, 0, 0, 1, 1, 5, 0, 12'h077, 1, 5'b11111, 0, 0, 0, 1};
        vecs[9]  = '{"busy_misp",  1,  2, 0, 0, 0, 1, 0, 3, 1, 12'h088, 1, 5'b11111, 0, 0, 0, 1};
        vecs[10] = '{"halt_lu",   31,  4, 1, 0, 1, 1, 1,31, 0, 12'h099, 0, 5'b11000, 0, 1, 0, 1};
        vecs[11] = '{"halt_misp",  1,  2, 0, 0, 1, 1, 0, 3, 1, 12'h0AB, 0, 5'b00000, 1, 1, 1, 0};

        RSTn = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        foreach (vecs[i]) begin
            @(negedge CLK);
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
            id_halt = vecs[i].halt; ex_valid = vecs[i].exv; ex_is_load = vecs[i].exld;
            ex_rd = vecs[i].exrd; ex_mispredict = vecs[i].misp;
            ex_target = vecs[i].tgt; dmem_busy = vecs[i].busy;
            #1;
            chk_outs(vecs[i].name, vecs[i].e_latch, vecs[i].e_ifl, vecs[i].e_idl, vecs[i].e_redir);
            chk({vecs[i].name, ".redirect_pc"}, 32'(redirect_pc), 32'(vecs[i].tgt));
            @(posedge CLK);
            #1;
            exp_stall += vecs[i].e_sinc;
            chk({vecs[i].name, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
            chk({vecs[i].name, ".halted"}, 32'(halted), 32'd0);
            $display("[TB] vec %0d %s latchn=%b ifl=%b idl=%b redir=%b stall=%0d",
                     i, vecs[i].name, latches(), ifid_flush, idex_flush, redirect, stall_cnt);
        end

        // Halt with no busy cycles: 3 DRAIN cycles, HALT state, halted on 4th edge.
        @(negedge CLK);
        idle_inputs();
        id_halt = 1'b1;
        #1;
        chk_outs("halt_capture", 5'b00000, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            idle_inputs();
            ex_mispredict = (k == 2);
            ex_target = 12'h123;
            #1;
            if (k <= 3) chk_outs($sformatf("drain%0d", k), 5'b11000, 1'b0, 1'b1, 1'b0);
            else        chk_outs("halt_state", 5'b11111, 1'b0, 1'b0, 1'b0);
            @(posedge CLK);
            #1;
            chk($sformatf("drain_halted_e%0d", k), 32'(halted), 32'(k >= 4));
            $display("[TB] drain edge %0d latchn=%b halted=%b", k, latches(), halted);
        end
        chk("drain.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Reset pulsed in HALT clears halted asynchronously.
        #2;
        RSTn = 1'b0;
        #1;
        chk("rst_halt.halted", 32'(halted), 32'd0);
        chk("rst_halt.stall_cnt", 32'(stall_cnt), 32'd0);
        chk_outs("rst_halt", 5'b11111, 1'b1, 1'b1, 1'b0);
        exp_stall = 0;
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        chk_outs("post_reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        $display("[TB] reset in HALT: halted=%b stall=%0d", halted, stall_cnt);

        // Halt with two busy cycles mid-DRAIN: halted delayed to edge 6, stall +2.
        @(negedge CLK);
        idle_inputs();
        id_halt = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            idle_inputs();
            dmem_busy = (k == 2) || (k == 3);
            #1;
            if (k == 2 || k == 3)  chk_outs($sformatf("bdrain_busy%0d", k), 5'b11111, 1'b0, 1'b0, 1'b0);
            else if (k <= 5)       chk_outs($sformatf("bdrain%0d", k), 5'b11000, 1'b0, 1'b1, 1'b0);
            else                   chk_outs("bdrain_halt", 5'b11111, 1'b0, 1'b0, 1'b0);
            @(posedge CLK);
            #1;
            chk($sformatf("bdrain_halted_e%0d", k), 32'(halted), 32'(k >= 6));
            $display("[TB] busy-drain edge %0d latchn=%b halted=%b stall=%0d",
                     k, latches(), halted, stall_cnt);
        end
        chk("bdrain.stall_cnt", 32'(stall_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing unit for the 5-stage pipeline: produces the per-stage `latchn` enables and `flush` bubbles for the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC. It detects load-use hazards, applies branch-mispredict redirects, freezes the pipe while data memory is busy, and drains the pipeline on a halt. It sits beside the datapath and drives every pipeline register's control pins.

## Interface
- `REG_W`, 5: register-index width.
- `PC_W`, 12: PC width.
- `DRAIN_CYCLES`, 3: cycles needed to retire the halt instruction through EX, MEM and WB.
- `CLK` in 1: clock. All state updates on the posedge.
- `RSTn` in 1: reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in REG_W: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the instruction in ID reads that source.
- `id_halt` in 1: the instruction in ID is a halt (the gated `probablyHalt`).
- `ex_valid` in 1: EX holds a real instruction, not a bubble.
- `ex_is_load` in 1: EX holds a load.
- `ex_rd` in REG_W: destination register of the instruction in EX.
- `ex_mispredict` in 1: a branch or jump resolved in EX was mispredicted.
- `ex_target` in PC_W: correct PC for that branch or jump.
- `dmem_busy` in 1: data memory has not completed its access this cycle.
- `pc_latchn`, `ifid_latchn`, `idex_latchn`, `exmem_latchn`, `memwb_latchn` out 1: per-stage hold (1 = hold, 0 = capture).
- `ifid_flush`, `idex_flush` out 1: the register being captured receives a bubble.
- `redirect` out 1: PC loads `redirect_pc` instead of the next sequential PC.
- `redirect_pc` out PC_W: equal to `ex_target`.
- `halted` out 1: the pipeline has stopped permanently.
- `stall_cnt` out 16: saturating count of stalled cycles.

## Operation
- States: RUN, DRAIN, HALT.
- Load-use hazard `lu` is true when all of the following hold:
  - `ex_valid`, `ex_is_load`, and `ex_rd != 0`;
  - `(id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)`.
- Default in RUN: all latchn = 0, flushes = 0, redirect = 0.
- Priority, highest first:
  - reset;
  - HALT;
  - `dmem_busy`;
  - `ex_mispredict`;
  - `lu`;
  - normal.
- `dmem_busy` (RUN or DRAIN):
  - all five latchn = 1, flushes = 0, redirect = 0;
  - state and drain counter unchanged.
- Mispredict (RUN):
  - redirect = 1, all latchn = 0;
  - `ifid_flush` = 1 and `idex_flush` = 1 (kills the two younger instructions);
  - `id_halt` is ignored in that cycle.
- Load-use (RUN):
  - `pc_latchn` = 1 and `ifid_latchn` = 1;
  - `idex_latchn` = 0 with `idex_flush` = 1 (one bubble);
  - EX_MEM and MEM_WB capture normally.
- RUN→DRAIN: `id_halt & ~ex_mispredict & ~lu & ~dmem_busy`.
  - The halt captures into ID_EX normally in that cycle.
  - The drain counter loads `DRAIN_CYCLES-1`.
- DRAIN:
  - `pc_latchn` = 1 and `ifid_latchn` = 1;
  - `idex_flush` = 1, downstream latches capture;
  - the counter decrements each non-busy cycle;
  - at 0 (and not busy) → HALT;
  - `ex_mispredict` is ignored (no older branch can remain in EX).
- HALT:
  - all latchn = 1, flushes = 0, `halted` = 1;
  - terminal until reset.
- `stall_cnt` increments on every cycle in RUN or DRAIN where `pc_latchn` = 1 due to `lu` or `dmem_busy`; it saturates at 0xFFFF. DRAIN front-end holds are not counted.

## Timing
- All outputs other than `halted` and `stall_cnt` are combinational from state and inputs (zero latency), consumed at the same clock edge.
- `halted` is registered from state. It rises one cycle after the last DRAIN cycle, i.e. `DRAIN_CYCLES+1` edges after the halt is captured into ID_EX, with no busy cycles.
- While RSTn = 0:
  - state = RUN, drain counter = 0, `stall_cnt` = 0, `halted` = 0;
  - all latchn = 1, `ifid_flush` = `idex_flush` = 1, redirect = 0.
- Reset asserted mid-DRAIN or in HALT returns the block to RUN asynchronously. The first capture happens at the first edge after release.
- Simultaneous `lu` and mispredict: mispredict wins (the stalled instruction is flushed anyway).
- Simultaneous `id_halt` and `lu`: stall first; DRAIN is entered on the following non-hazard cycle.
- `ex_rd == 0` never raises a hazard.

## Structure
- Package `pipeline_ctrl_pkg`:
  - state enum (2-bit);
  - `REG_W`, `PC_W`, `DRAIN_CYCLES` defaults;
  - `STALL_CNT_W` = 16.
- Sub-module `hazard_detect`: combinational load-use comparator producing `lu`; instantiated once.
- Top holds the FSM, drain counter, stall counter and output decode.

## Test plan
- Load to x5 in EX with `ex_valid`=1, and ID uses rs1=5 with `id_use_rs1`=1 → one cycle of `pc_latchn`=`ifid_latchn`=1, `idex_flush`=1; `stall_cnt` 0→1.
- Same with `ex_rd`=0, or with `id_use_rs1`=0 → no stall, all latchn=0.
- `ex_mispredict`=1 with `ex_target`=0x040 and `lu` true in the same cycle → redirect=1, `redirect_pc`=0x040, both flushes=1, no hold.
- `id_halt`=1 in RUN → DRAIN for 3 cycles with `idex_flush`=1 and the front end held; `halted`=1 on the 4th edge; all latchn=1 afterwards.
- `dmem_busy`=1 for 2 cycles in mid-DRAIN → all latchn=1, counter frozen; `halted` is delayed by exactly 2 cycles; `stall_cnt` +2.
- RSTn pulsed low in HALT → `halted`=0 immediately; `stall_cnt`=0; normal capture after release.
